// File: rtl/opl3_pkg.sv
// Shared definitions for the register-file write path.
// Provides the default register-file geometry, the address/data pair that
// travels through the write queue, and the write-queue state encoding.
package opl3_pkg;

   localparam int REG_FILE_ADDR_WIDTH = 9;
   localparam int REG_DATA_WIDTH      = 8;

   // One host register write as it sits in the queue
   typedef struct packed {
      logic [REG_FILE_ADDR_WIDTH-1:0] addr;
      logic [REG_DATA_WIDTH-1:0]      data;
   } reg_write_t;

   // INIT sweeps the memory after reset, RUN drains host writes
   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } reg_write_queue_state_t;

endpackage

// File: rtl/reg_write_queue_if.sv
// Bus bundle for reg_write_queue.
// Host side : wr_valid/wr_addr/wr_data in, wr_ready out.
// Pipeline  : drain_en (idle window), clear_overflow.
// Memory    : mem_wea/mem_addra/mem_dia to port A of the register file.
// Status    : init_done, overflow (sticky), level (FIFO occupancy).
// slave = the queue itself, master = whoever drives host/pipeline inputs.
interface reg_write_queue_if #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic                  wr_valid;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_ready;
   logic                  drain_en;
   logic                  clear_overflow;
   logic                  mem_wea;
   logic [ADDR_WIDTH-1:0] mem_addra;
   logic [DATA_WIDTH-1:0] mem_dia;
   logic                  init_done;
   logic                  overflow;
   logic [LW-1:0]         level;

   modport slave (
      input  wr_valid, wr_addr, wr_data, drain_en, clear_overflow,
      output wr_ready, mem_wea, mem_addra, mem_dia, init_done, overflow, level
   );

   modport master (
      output wr_valid, wr_addr, wr_data, drain_en, clear_overflow,
      input  wr_ready, mem_wea, mem_addra, mem_dia, init_done, overflow, level
   );
endinterface

// File: rtl/reg_write_queue_fifo.sv
// sync_fifo: generic single-clock FIFO.
// Ports: clk, reset_n (async active-low), i_push/i_data write side,
// i_pop/o_data read side (o_data shows the head entry combinationally),
// o_full, o_empty, o_level (0..DEPTH).
// A push while full or a pop while empty is ignored. DEPTH must be a power
// of two so the pointers wrap naturally.
module sync_fifo
   import opl3_pkg::*;
#(
   parameter type T     = reg_write_t,
   parameter int  DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   i_push,
   input  T                       i_data,
   input  logic                   i_pop,
   output T                       o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_level
);
   localparam int PW = $clog2(DEPTH);

   T               r_mem [DEPTH];
   logic [PW-1:0]  r_wrPtr;
   logic [PW-1:0]  r_rdPtr;
   logic [PW:0]    r_level;
   logic           w_doPush;
   logic           w_doPop;

   assign o_full   = (r_level == (PW+1)'(DEPTH));
   assign o_empty  = (r_level == '0);
   assign o_level  = r_level;
   assign o_data   = r_mem[r_rdPtr];
   assign w_doPush = i_push && !o_full;
   assign w_doPop  = i_pop && !o_empty;

   // Storage has no reset; only pointers and the count define validity
   always_ff @(posedge clk) begin
      if (w_doPush)
         r_mem[r_wrPtr] <= i_data;
   end

   // Pointers wrap naturally; level is kept as an explicit counter so a
   // full queue is distinguishable from an empty one
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
      end else begin
         if (w_doPush)
            r_wrPtr <= r_wrPtr + 1'b1;
         if (w_doPop)
            r_rdPtr <= r_rdPtr + 1'b1;
         if (w_doPush && !w_doPop)
            r_level <= r_level + 1'b1;
         else if (w_doPop && !w_doPush)
            r_level <= r_level - 1'b1;
      end
   end
endmodule

// File: rtl/reg_write_queue.sv
// reg_write_queue: buffers host register writes and drains them into the
// register-file write port only during pipeline idle windows.
// Ports: clk, reset_n (async active-low), bus (reg_write_queue_if.slave).
// After reset the whole memory is swept with INIT_VALUE (state INIT); host
// writes may be queued meanwhile but are only drained once in RUN.
module reg_write_queue
   import opl3_pkg::*;
#(
   parameter int                    ADDR_WIDTH    = REG_FILE_ADDR_WIDTH,
   parameter int                    DATA_WIDTH    = REG_DATA_WIDTH,
   parameter int                    FIFO_DEPTH    = 16,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
   parameter bit                    INIT_ON_RESET = 1'b1
) (
   input  logic               clk,
   input  logic               reset_n,
   reg_write_queue_if.slave   bus
);
   localparam int          LW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [0:0]  ST_INIT = INIT;
   localparam logic [0:0]  ST_RUN  = RUN;
   localparam logic [0:0]  ST_RST  = INIT_ON_RESET ? ST_INIT : ST_RUN;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   logic [0:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_sweepAddr;
   logic                  r_memWea;
   logic [ADDR_WIDTH-1:0] r_memAddra;
   logic [DATA_WIDTH-1:0] r_memDia;
   logic                  r_initDone;
   logic                  r_overflow;
   entry_t                w_pushData;
   entry_t                w_headData;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic [LW-1:0]         w_level;

   // A full queue refuses writes even if a pop happens in the same cycle
   assign w_push     = bus.wr_valid && !w_full;
   assign w_pop      = (r_state == ST_RUN) && bus.drain_en && !w_empty;
   assign w_pushData = '{addr: bus.wr_addr, data: bus.wr_data};

   sync_fifo #(
      .T     (entry_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_data  (w_pushData),
      .i_pop   (w_pop),
      .o_data  (w_headData),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   // Port A is owned by the sweep in INIT and by the FIFO head in RUN;
   // address/data hold their last value when no write is issued
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_RST;
         r_sweepAddr <= '0;
         r_memWea    <= 1'b0;
         r_memAddra  <= '0;
         r_memDia    <= '0;
      end else if (r_state == ST_INIT) begin
         r_memWea    <= 1'b1;
         r_memAddra  <= r_sweepAddr;
         r_memDia    <= INIT_VALUE;
         r_sweepAddr <= r_sweepAddr + 1'b1;
         if (r_sweepAddr == '1)
            r_state <= ST_RUN;
      end else begin
         r_memWea <= w_pop;
         if (w_pop) begin
            r_memAddra <= w_headData.addr;
            r_memDia   <= w_headData.data;
         end
      end
   end

   // init_done lags the state change by one cycle so it rises only after
   // the final sweep address has been presented
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_initDone <= !INIT_ON_RESET;
      else if (r_state == ST_RUN)
         r_initDone <= 1'b1;
   end

   // Sticky drop flag; a drop in the same cycle as a clear keeps it set
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_overflow <= 1'b0;
      else if (bus.wr_valid && w_full)
         r_overflow <= 1'b1;
      else if (bus.clear_overflow)
         r_overflow <= 1'b0;
   end

   assign bus.wr_ready  = !w_full;
   assign bus.mem_wea   = r_memWea;
   assign bus.mem_addra = r_memAddra;
   assign bus.mem_dia   = r_memDia;
   assign bus.init_done = r_initDone;
   assign bus.overflow  = r_overflow;
   assign bus.level     = w_level;
endmodule

// File: tb/tb_reg_write_queue.sv
// Testbench for reg_write_queue. Stimulus pushes every expected port-A write
// (sweep writes and host writes) into a scoreboard queue; a negedge monitor
// pops and compares whenever mem_wea is high.
module tb_reg_write_queue;

   typedef struct {
      logic [8:0] addr;
      logic [7:0] data;
      bit         sweep;
   } exp_t;

   logic clk;
   logic reset_n;
   logic prevDrain;
   int   checks;
   int   errors;
   exp_t expQ[$];

   reg_write_queue_if #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .FIFO_DEPTH(16)) bus();

   reg_write_queue #(
      .ADDR_WIDTH    (9),
      .DATA_WIDTH    (8),
      .FIFO_DEPTH    (16),
      .INIT_VALUE    (8'h00),
      .INIT_ON_RESET (1'b1)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // drain_en as seen by the DUT at each rising edge
   always @(posedge clk) prevDrain <= bus.drain_en;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every port-A write must match the head of the scoreboard
   always @(negedge clk) begin
      if (reset_n === 1'b1 && bus.mem_wea === 1'b1) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedWrite actual addr=0x%0h data=0x%0h expected no write",
                     bus.mem_addra, bus.mem_dia);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("memAddra", 32'(bus.mem_addra), 32'(e.addr));
            checkOutput("memDia", 32'(bus.mem_dia), 32'(e.data));
            if (e.sweep)
               checkOutput("initDoneDuringSweep", 32'(bus.init_done), 32'd0);
            else begin
               checkOutput("initDoneBeforeDrain", 32'(bus.init_done), 32'd1);
               checkOutput("drainEnBeforeWrite", 32'(prevDrain), 32'd1);
            end
         end
      end
   end

   // One cycle of inputs; a write marked expect is queued in the scoreboard
   task automatic applyStimulus(input logic v, input logic [8:0] a, input logic [7:0] d,
                                input logic dr, input bit expectIt);
      exp_t e;
      bus.wr_valid = v;
      bus.wr_addr  = a;
      bus.wr_data  = d;
      bus.drain_en = dr;
      if (v && expectIt) begin
         e.addr  = a;
         e.data  = d;
         e.sweep = 1'b0;
         expQ.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.wr_valid = 1'b0;
   endtask

   task automatic idle(input int n, input logic dr);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, 9'h000, 8'h00, dr, 1'b0);
   endtask

   task automatic queueSweep();
      exp_t e;
      for (int i = 0; i < 512; i++) begin
         e.addr  = 9'(i);
         e.data  = 8'h00;
         e.sweep = 1'b1;
         expQ.push_back(e);
      end
   endtask

   task automatic waitDrain(input int maxCycles, input string name);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < maxCycles) begin
         @(posedge clk);
         #1;
         n++;
      end
      @(negedge clk);
      #1;
      checkOutput(name, 32'(expQ.size()), 32'd0);
   endtask

   // Asynchronous reset asserted just after an edge; outputs must clear
   // before the next edge
   task automatic assertReset();
      reset_n = 1'b0;
      expQ.delete();
      #1;
      checkOutput("rstWea", 32'(bus.mem_wea), 32'd0);
      checkOutput("rstAddra", 32'(bus.mem_addra), 32'd0);
      checkOutput("rstDia", 32'(bus.mem_dia), 32'd0);
      checkOutput("rstLevel", 32'(bus.level), 32'd0);
      checkOutput("rstOverflow", 32'(bus.overflow), 32'd0);
      checkOutput("rstInitDone", 32'(bus.init_done), 32'd0);
      checkOutput("rstWrReady", 32'(bus.wr_ready), 32'd1);
      @(posedge clk);
      #1;
      queueSweep();
      reset_n = 1'b1;
   endtask

   initial begin
      int cnt;
      checks              = 0;
      errors              = 0;
      reset_n             = 1'b1;
      bus.wr_valid        = 1'b0;
      bus.wr_addr         = '0;
      bus.wr_data         = '0;
      bus.drain_en        = 1'b0;
      bus.clear_overflow  = 1'b0;
      @(posedge clk);
      #1;
      assertReset();

      // Three host writes during the sweep, drain_en already high
      applyStimulus(1'b1, 9'h011, 8'hA1, 1'b1, 1'b1);
      applyStimulus(1'b1, 9'h022, 8'hA2, 1'b1, 1'b1);
      applyStimulus(1'b1, 9'h033, 8'hA3, 1'b1, 1'b1);
      checkOutput("levelDuringInit", 32'(bus.level), 32'd3);
      checkOutput("initDoneEarly", 32'(bus.init_done), 32'd0);
      cnt = 3;
      while (bus.init_done !== 1'b1 && cnt < 700) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      checkOutput("initDoneCycle", 32'(cnt), 32'd513);
      waitDrain(20, "initQueueDrain");
      idle(2, 1'b1);

      // Minimum latency: accepted at edge N, written in cycle N+2
      applyStimulus(1'b1, 9'h0A0, 8'h5C, 1'b1, 1'b1);
      checkOutput("latWeaEarly", 32'(bus.mem_wea), 32'd0);
      checkOutput("latLevel1", 32'(bus.level), 32'd1);
      idle(1, 1'b1);
      checkOutput("latWea", 32'(bus.mem_wea), 32'd1);
      checkOutput("latAddra", 32'(bus.mem_addra), 32'h0A0);
      checkOutput("latDia", 32'(bus.mem_dia), 32'h5C);
      checkOutput("latLevel0", 32'(bus.level), 32'd0);
      idle(2, 1'b0);
      checkOutput("holdAddra", 32'(bus.mem_addra), 32'h0A0);
      checkOutput("holdWea", 32'(bus.mem_wea), 32'd0);

      // Fill to 16, then one dropped write
      for (int i = 0; i < 16; i++)
         applyStimulus(1'b1, 9'(9'h100 + i), 8'(8'hB0 + i), 1'b0, 1'b1);
      checkOutput("fullWrReady", 32'(bus.wr_ready), 32'd0);
      checkOutput("fullLevel", 32'(bus.level), 32'd16);
      applyStimulus(1'b1, 9'h1FF, 8'hEE, 1'b0, 1'b0);
      checkOutput("overflowSet", 32'(bus.overflow), 32'd1);
      checkOutput("fullLevelAfterDrop", 32'(bus.level), 32'd16);
      bus.drain_en = 1'b1;
      waitDrain(40, "fullDrain");
      checkOutput("overflowSticky", 32'(bus.overflow), 32'd1);
      checkOutput("drainedLevel", 32'(bus.level), 32'd0);
      bus.clear_overflow = 1'b1;
      idle(1, 1'b1);
      bus.clear_overflow = 1'b0;
      checkOutput("overflowCleared", 32'(bus.overflow), 32'd0);

      // Same address twice with drain_en toggling each cycle
      applyStimulus(1'b1, 9'h020, 8'h11, 1'b0, 1'b1);
      applyStimulus(1'b1, 9'h020, 8'h22, 1'b1, 1'b1);
      idle(1, 1'b0);
      idle(1, 1'b1);
      idle(1, 1'b0);
      idle(1, 1'b1);
      waitDrain(10, "toggleDrain");
      checkOutput("lastWriteWins", 32'(bus.mem_dia), 32'h22);

      // Reset mid-sweep with 5 entries queued; they must never appear
      @(posedge clk);
      #1;
      assertReset();
      idle(100, 1'b0);
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 9'(9'h150 + i), 8'(8'hC0 + i), 1'b0, 1'b0);
      checkOutput("midSweepLevel", 32'(bus.level), 32'd5);
      assertReset();
      bus.drain_en = 1'b1;
      cnt = 0;
      while (bus.init_done !== 1'b1 && cnt < 700) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      checkOutput("resweepInitDone", 32'(cnt), 32'd513);
      idle(10, 1'b1);
      checkOutput("resweepQueueEmpty", 32'(expQ.size()), 32'd0);
      checkOutput("resweepLevel", 32'(bus.level), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
